pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline stall/flush controller for the in-order RISC-V core; generalises the fixed 5-stage stall chain to NSTAGE stages.
- Adds a bubble-collapsing mode, flush handling with deferral, rdy freeze, a stall watchdog and performance counters.
- Sits beside the pipeline registers; drives the hold and bubble enables of every register, including the PC.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-register hold/bubble enables, deferred
// flush handling, stall watchdog and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned NSTAGE   = 5,
  parameter int unsigned COLLAPSE = 0,
  parameter int unsigned SW       = $clog2(NSTAGE),
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WDOG_LIM = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NSTAGE-1:0] valid,
  input  logic              flush_req,
  input  logic [SW-1:0]     flush_stage,
  output logic [NSTAGE-1:0] hold,
  output logic [NSTAGE-1:0] bubble,
  output logic              redirect,
  output logic              flush_pend,
  output logic              wdog_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned WD_W = $clog2(WDOG_LIM + 1);
  localparam logic [SW-1:0] LAST_K = SW'(NSTAGE - 1);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SW-1:0]      r_pend_k;
  logic [SW-1:0]      w_pend_k_nxt;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_wdog_err;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic [NSTAGE:0]    w_base_hold;
  logic [NSTAGE-1:0]  w_valid;
  logic [SW-1:0]      w_live_k;
  logic [SW-1:0]      w_eff_k;
  logic               w_pend;
  logic               w_eff_vld;
  logic               w_above_hold;
  logic               w_accept;

  assign w_valid    = valid | NSTAGE'(1);
  assign w_pend     = (r_state == S_PEND);
  assign w_live_k   = (flush_stage >= LAST_K) ? LAST_K : flush_stage;
  assign w_eff_vld  = w_pend | flush_req;
  // A live request at the same or an older stage supersedes the pending one.
  assign w_eff_k    = (w_pend && !(flush_req && (w_live_k >= r_pend_k))) ? r_pend_k : w_live_k;
  assign w_accept   = rdy & w_eff_vld & ~w_above_hold;

  // Base stall chain, walked from the oldest stage towards the PC.
  always_comb begin
    w_base_hold = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (COLLAPSE != 0) w_base_hold[i] = stall_req[i] | (w_base_hold[i+1] & w_valid[i]);
      else               w_base_hold[i] = stall_req[i] | w_base_hold[i+1];
    end
  end

  always_comb begin
    w_above_hold = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (SW'(i) == w_eff_k) w_above_hold = w_base_hold[i+1];
    end
  end

  // Flush FSM next state and zero-latency hold/bubble/redirect.
  always_comb begin
    w_state_nxt  = r_state;
    w_pend_k_nxt = r_pend_k;
    hold         = '0;
    bubble       = '0;
    redirect     = 1'b0;
    case (r_state)
      S_IDLE: if (flush_req && !w_accept) begin
        w_state_nxt  = S_PEND;
        w_pend_k_nxt = w_eff_k;
      end
      S_PEND: if (w_accept) w_state_nxt = S_IDLE;
              else          w_pend_k_nxt = w_eff_k;
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      hold = '0;
    end else if (!rdy) begin
      hold = '1;
    end else begin
      hold = w_base_hold[NSTAGE-1:0];
      for (int i = 1; i < NSTAGE; i++) bubble[i] = w_base_hold[i-1] & ~w_base_hold[i];
      if (w_accept) begin
        redirect = 1'b1;
        for (int i = 0; i < NSTAGE; i++) begin
          if (SW'(i) <= w_eff_k) begin
            hold[i] = 1'b0;
            if (i >= 1) bubble[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pend_k <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend_k <= w_pend_k_nxt;
    end
  end

  // Watchdog and perf counters only move while the pipe is not frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt    <= '0;
      r_wdog_err  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (rdy) begin
      if (hold[0] && !redirect) begin
        if (r_wd_cnt != WD_W'(WDOG_LIM)) r_wd_cnt <= r_wd_cnt + WD_W'(1);
        if (r_wd_cnt >= WD_W'(WDOG_LIM - 1)) r_wdog_err <= 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
      if (hold[0] && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign flush_pend = w_pend;
  assign wdog_err   = r_wdog_err;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: strict-chain instance (WDOG_LIM=8) plus
// a collapse-mode instance sharing the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b1;
  logic [4:0] stall_req = '0;
  logic [4:0] valid = '1;
  logic       flush_req = 1'b0;
  logic [2:0] flush_stage = '0;

  logic [4:0]  s_hold, s_bubble, c_hold, c_bubble;
  logic        s_redirect, s_pend, s_wdog, c_redirect, c_pend, c_wdog;
  logic [31:0] s_scnt, s_fcnt, c_scnt, c_fcnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGE(5), .COLLAPSE(0), .WDOG_LIM(8)) u_strict (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .valid(valid),
    .flush_req(flush_req), .flush_stage(flush_stage), .hold(s_hold), .bubble(s_bubble),
    .redirect(s_redirect), .flush_pend(s_pend), .wdog_err(s_wdog),
    .stall_cnt(s_scnt), .flush_cnt(s_fcnt));

  pipe_hazard_ctrl #(.NSTAGE(5), .COLLAPSE(1), .WDOG_LIM(8)) u_collapse (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .valid(valid),
    .flush_req(flush_req), .flush_stage(flush_stage), .hold(c_hold), .bubble(c_bubble),
    .redirect(c_redirect), .flush_pend(c_pend), .wdog_err(c_wdog),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  typedef struct {
    int          cyc;
    logic [4:0]  hold, bubble;
    logic        red, pend, wdog;
    logic [31:0] scnt, fcnt;
    bit          chk_col;
    logic [4:0]  chold, cbub;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  bit   col_chk = 1'b0;
  logic [4:0] col_hold = '0, col_bub = '0;

  task automatic cmp(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc%0d got %0h want %0h", nm, c, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the response expected at the following negedge.
  task automatic cyc(input logic r, input logic rd, input logic [4:0] st, input logic [4:0] va,
                     input logic fr, input logic [2:0] fs,
                     input logic [4:0] eh, input logic [4:0] eb, input logic er,
                     input logic ep, input logic ew, input int esc, input int efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rdy = rd; stall_req = st; valid = va; flush_req = fr; flush_stage = fs;
    e.cyc = cyc_no; e.hold = eh; e.bubble = eb; e.red = er; e.pend = ep; e.wdog = ew;
    e.scnt = 32'(esc); e.fcnt = 32'(efc);
    e.chk_col = col_chk; e.chold = col_hold; e.cbub = col_bub;
    q.push_back(e);
    cyc_no++;
    col_chk = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("hold",       e.cyc, 32'(s_hold),     32'(e.hold));
      cmp("bubble",     e.cyc, 32'(s_bubble),   32'(e.bubble));
      cmp("redirect",   e.cyc, 32'(s_redirect), 32'(e.red));
      cmp("flush_pend", e.cyc, 32'(s_pend),     32'(e.pend));
      cmp("wdog_err",   e.cyc, 32'(s_wdog),     32'(e.wdog));
      cmp("stall_cnt",  e.cyc, s_scnt,          e.scnt);
      cmp("flush_cnt",  e.cyc, s_fcnt,          e.fcnt);
      if (e.chk_col) begin
        cmp("col_hold",   e.cyc, 32'(c_hold),     32'(e.chold));
        cmp("col_bubble", e.cyc, 32'(c_bubble),   32'(e.cbub));
        cmp("col_redir",  e.cyc, 32'(c_redirect), 32'(0));
      end
    end
  end

  initial begin
    // reset, outputs gated even with live requests
    cyc(1, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    cyc(1, 1, 5'b01000, 5'b11111, 1, 2, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    // strict vs collapse with a bubble in slot 2
    col_chk = 1; col_hold = 5'b01000; col_bub = 5'b10000;
    cyc(0, 1, 5'b01000, 5'b11011, 0, 0, 5'b01111, 5'b10000, 0, 0, 0, 0, 0);
    col_chk = 1; col_hold = 5'b01111; col_bub = 5'b10000;
    cyc(0, 1, 5'b01000, 5'b11111, 0, 0, 5'b01111, 5'b10000, 0, 0, 0, 1, 0);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 2, 0);
    // immediate flush of stage 2
    cyc(0, 1, 5'b00000, 5'b11111, 1, 2, 5'b00000, 5'b00110, 1, 0, 0, 2, 0);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 2, 1);
    // deferred flush of stage 1 behind a stage-3 stall
    cyc(0, 1, 5'b01000, 5'b11111, 1, 1, 5'b01111, 5'b10000, 0, 0, 0, 2, 1);
    cyc(0, 1, 5'b01000, 5'b11111, 0, 0, 5'b01111, 5'b10000, 0, 1, 0, 3, 1);
    cyc(0, 1, 5'b01000, 5'b11111, 0, 0, 5'b01111, 5'b10000, 0, 1, 0, 4, 1);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00010, 1, 1, 0, 5, 1);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 5, 2);
    // replacement by stage 3, stage 0 request ignored, then accept stage 3
    cyc(0, 1, 5'b10000, 5'b11111, 1, 1, 5'b11111, 5'b00000, 0, 0, 0, 5, 2);
    cyc(0, 1, 5'b10000, 5'b11111, 1, 3, 5'b11111, 5'b00000, 0, 1, 0, 6, 2);
    cyc(0, 1, 5'b10000, 5'b11111, 1, 0, 5'b11111, 5'b00000, 0, 1, 0, 7, 2);
    cyc(0, 1, 5'b01000, 5'b11111, 0, 0, 5'b00000, 5'b11110, 1, 1, 0, 8, 2);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 8, 3);
    // rdy freeze captures a live flush
    cyc(0, 0, 5'b00000, 5'b11111, 1, 2, 5'b11111, 5'b00000, 0, 0, 0, 8, 3);
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 5'b00000, 5'b11111, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 8, 3);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00110, 1, 1, 0, 8, 3);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 8, 4);
    // watchdog: 8 stalled cycles trip it after the 8th edge
    for (int k = 0; k < 8; k++)
      cyc(0, 1, 5'b00001, 5'b11111, 0, 0, 5'b00001, 5'b00010, 0, 0, 0, 8 + k, 4);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 1, 16, 4);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 1, 16, 4);
    // mid-run reset clears everything on the next edge
    cyc(1, 1, 5'b01000, 5'b11111, 1, 2, 5'b00000, 5'b00000, 0, 0, 1, 16, 4);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    // out-of-range stage clamps to the last stage and is always accepted
    cyc(0, 1, 5'b10000, 5'b11111, 1, 7, 5'b00000, 5'b11110, 1, 0, 0, 0, 0);
    cyc(0, 1, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d queued want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
